// File: rtl/i2c_slave_regfile.sv
// I2C slave register file. NUM_RW read/write bytes sit at indices
// 0..NUM_RW-1 and NUM_RO read-only bytes follow. One 8-bit pointer covers
// both ranges. The pointer auto-increments after every data byte and wraps
// from the last register back to 0.
// SCL/SDA are oversampled on clk: a 2-flop synchroniser feeds a
// consecutive-sample filter, and all bus decoding uses the filtered lines.
// Strobe semantics: wr_pulse is a one-clk valid with no ready. wr_index and
// the updated rw_regs byte are valid in the same clk. There is no
// back-pressure, so the consumer must take it on that clk.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         NUM_RW   = 4,
    parameter int         NUM_RO   = 4,
    parameter int         FILT     = 3
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire                 sda,
    input  logic                scl,
    output logic [8*NUM_RW-1:0] rw_regs,
    input  logic [8*NUM_RO-1:0] ro_regs,
    output logic                wr_pulse,
    output logic [7:0]          wr_index,
    output logic                busy,
    output logic [3:0]          state_dbg
);

    localparam logic [7:0] TOTAL = 8'(NUM_RW + NUM_RO);
    localparam logic [7:0] LAST  = 8'(NUM_RW + NUM_RO - 1);
    localparam logic [3:0] FLIM  = 4'(FILT - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, A_ACK, PTR, P_ACK, WR, W_ACK, RD, M_ACK
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic [3:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;        // remaining read bits after the one on the bus
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       mack_q, mack_d;
    logic       wr_pulse_q, wr_pulse_d;
    logic [7:0] wr_index_q, wr_index_d;
    logic [7:0] rw_q [NUM_RW];
    logic [7:0] rw_d [NUM_RW];

    logic [7:0] rd_byte, new_byte, ptr_inc;
    logic       in_range, is_rw;

    // Synchronise both lines and only let the filtered value follow after FILT equal samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= 4'd0;
            sda_cnt  <= 4'd0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_p    <= scl_f;
            sda_p    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= 4'd0;
            end else if (scl_cnt == FLIM) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= 4'd0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= 4'd0;
            end else if (sda_cnt == FLIM) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= 4'd0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    // SCL edges and START/STOP conditions. SCL must be high in both samples for a condition.
    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;

    assign new_byte = {shift_q[6:0], sda_f};
    assign ptr_inc  = (ptr_q == LAST) ? 8'd0 : ptr_q + 8'd1;
    assign in_range = ptr_q < TOTAL;
    assign is_rw    = ptr_q < 8'(NUM_RW);

    // Byte at the pointer for a read: RW bank, then RO bank, else all ones.
    always_comb begin
        rd_byte = 8'hFF;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ptr_q == 8'(i)) rd_byte = rw_q[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (ptr_q == 8'(NUM_RW + i)) rd_byte = ro_regs[8*i +: 8];
        end
    end

    // Next-state and datapath. Bus conditions override bit events in the same clk.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        mack_d     = mack_q;
        wr_pulse_d = 1'b0;
        wr_index_d = wr_index_q;
        rw_d       = rw_q;
        if (stop_ev) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (start_ev) begin
            state_d = ADDR;
            bit_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = new_byte;
                        bit_d   = bit_q + 4'd1;
                    end else if (scl_fall && bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d = A_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                A_ACK: begin
                    if (scl_fall) begin
                        bit_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d = RD;
                            tx_d    = rd_byte[6:0];
                            oe_d    = ~rd_byte[7];
                        end else begin
                            state_d = PTR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_d = new_byte;
                        bit_d   = bit_q + 4'd1;
                    end else if (scl_fall && bit_q == 4'd8) begin
                        ptr_d   = shift_q;
                        oe_d    = shift_q < TOTAL;
                        state_d = P_ACK;
                    end
                end
                P_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        bit_d   = 4'd0;
                        state_d = WR;
                    end
                end
                WR: begin
                    if (scl_rise) begin
                        shift_d = new_byte;
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd7 && is_rw) begin
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (ptr_q == 8'(i)) rw_d[i] = new_byte;
                            end
                            wr_pulse_d = 1'b1;
                            wr_index_d = ptr_q;
                        end
                    end else if (scl_fall && bit_q == 4'd8) begin
                        oe_d    = in_range;
                        state_d = W_ACK;
                    end
                end
                W_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_inc;
                        bit_d   = 4'd0;
                        state_d = WR;
                    end
                end
                RD: begin
                    if (scl_rise) begin
                        bit_d = bit_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_q == 4'd8) begin
                            oe_d    = 1'b0;
                            ptr_d   = ptr_inc;
                            state_d = M_ACK;
                        end else begin
                            oe_d = ~tx_q[6];
                            tx_d = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                M_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_f;
                    end else if (scl_fall) begin
                        bit_d = 4'd0;
                        if (!mack_q) begin
                            state_d = RD;
                            tx_d    = rd_byte[6:0];
                            oe_d    = ~rd_byte[7];
                        end else begin
                            state_d = IDLE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers. Reset releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_q      <= 4'd0;
            shift_q    <= 8'd0;
            tx_q       <= 7'd0;
            ptr_q      <= 8'd0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            mack_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_index_q <= 8'd0;
            for (int i = 0; i < NUM_RW; i++) rw_q[i] <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            mack_q     <= mack_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
            rw_q       <= rw_d;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
        assign rw_regs[8*g +: 8] = rw_q[g];
    end

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign wr_pulse  = wr_pulse_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
